mips_mc_ctrl: RTL and testbench
===============================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, the maximum number of wait cycles allowed per memory request.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports op and func, inputs, 6 each, taken from the instruction register.
REQ-006 SHALL have port zero, input, 1, the ALU equality flag.
REQ-007 SHALL have port mem_ready, input, 1, which completes the current memory request.
REQ-008 SHALL have port mem_req, output, 1, a memory access request (fetch or data).
REQ-009 SHALL have ports ir_we, pc_we, grf_we and dm_we, outputs, 1 each, the write enables.
REQ-010 SHALL have ports regdst, wdsel, npcsel and extop, outputs, 2 each, the datapath selects.
REQ-011 SHALL have ports alusrc (1) and aluop (3), outputs, the ALU controls.
REQ-012 SHALL have port illegal, output, 1, a one-cycle pulse on an unknown opcode.
REQ-013 SHALL have port fault, output, 1, sticky, set on memory timeout.
REQ-014 SHALL have port retired, output, CNT_W, the count of completed instructions.

Function
REQ-015 SHALL implement the states FETCH, DECODE, EXE, MEM, WB and FAULT, each registered, one cycle minimum.
REQ-016 In FETCH, SHALL assert mem_req; on mem_ready, SHALL pulse ir_we and pc_we with npcsel=PC4 and go to DECODE.
REQ-017 In DECODE, j SHALL pulse pc_we with npcsel=J and go to FETCH.
REQ-018 In DECODE, jal SHALL also pulse grf_we with regdst=RA and wdsel=PC4.
REQ-019 In DECODE, jr (op 0, func 001000) SHALL pulse pc_we with npcsel=REG and go to FETCH.
REQ-020 In DECODE, an unknown op or R-type func SHALL pulse illegal, write nothing and go to FETCH.
REQ-021 In DECODE, every other supported instruction SHALL go to EXE.
REQ-022 The supported instructions SHALL be addu, subu, ori, lui, lw, sw, beq, j, jal and jr.
REQ-023 In EXE, beq SHALL pulse pc_we with npcsel=BR only when zero=1, then go to FETCH.
REQ-024 In EXE, lw and sw SHALL go to MEM; addu, subu, ori and lui SHALL go to WB.
REQ-025 In MEM, SHALL assert mem_req and, for sw, hold dm_we=1 while waiting.
REQ-026 In MEM, on mem_ready, sw SHALL go to FETCH and lw SHALL go to WB.
REQ-027 In WB, SHALL pulse grf_we for exactly one cycle, then go to FETCH.
REQ-028 A wait counter SHALL clear on each request start.
REQ-029 If mem_ready is absent for MEM_TIMEOUT+1 consecutive request cycles, SHALL go to FAULT with fault=1.
REQ-030 In FAULT, SHALL hold all enables at 0 until reset.
REQ-031 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-032 A mem_ready coincident with the timeout cycle SHALL count as success.
REQ-033 retired SHALL increment by 1, wrapping modulo 2^CNT_W, on every transition into FETCH other than from reset; illegal instructions count.
REQ-034 All selects SHALL be Moore outputs decoded from state, op and func.
REQ-035 Write enables SHALL be 0 in any state not naming them.

Reset
REQ-036 On reset, state SHALL be FETCH; retired, fault, illegal, the wait counter and all enables SHALL be 0; reset SHALL override FAULT and any in-progress request.

Configuration
REQ-037 With SLT_INSN_EN defined, SHALL decode slt (func 101010) via EXE/WB with aluop=SLT; without it, slt SHALL be illegal.

Structure
REQ-038 The state, npcsel, regdst, wdsel, extop and aluop encodings, plus the opcode and func constants, SHALL live in the shared package mips_pkg.
REQ-039 A sub-module mem_wait_timer (counter plus timeout compare) SHALL be used.

Verification
REQ-040 With mem_ready=1 always, addu SHALL take 4 cycles FETCH->DECODE->EXE->WB with one grf_we pulse, and retired 0->1.
REQ-041 lw with mem_ready delayed 3 cycles in MEM SHALL take 4 MEM cycles, then WB, with grf_we=1 exactly once.
REQ-042 beq with zero=0 SHALL never assert pc_we in EXE; with zero=1, SHALL assert pc_we with npcsel=BR.
REQ-043 With mem_ready held 0 in FETCH and MEM_TIMEOUT=15, SHALL set fault after 16 cycles, then hold until reset returns to FETCH with retired=0.
REQ-044 With CNT_W=4 and 16 nops, retired SHALL wrap to 0; op 111111 SHALL pulse illegal once and reach FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings and instruction classifier for the multicycle MIPS control.
// Optional slt decode is enabled by defining SLT_INSN_EN.
package mips_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXE,
        S_MEM,
        S_WB,
        S_FAULT
    } state_t;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_SLT, I_ORI, I_LUI, I_LW,
        I_SW, I_BEQ, I_J, I_JAL, I_JR, I_ILL
    } insn_t;

    localparam logic [1:0] NPC_PC4 = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_REG = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_SLT  = 6'b101010;

    function automatic insn_t decode_insn(input logic [5:0] op,
                                          input logic [5:0] func);
        insn_t i;
        i = I_ILL;
        case (op)
            OP_RTYPE: begin
                case (func)
                    F_ADDU: i = I_ADDU;
                    F_SUBU: i = I_SUBU;
                    F_JR:   i = I_JR;
`ifdef SLT_INSN_EN
                    F_SLT:  i = I_SLT;
`endif
                    default: i = I_ILL;
                endcase
            end
            OP_ORI:  i = I_ORI;
            OP_LUI:  i = I_LUI;
            OP_LW:   i = I_LW;
            OP_SW:   i = I_SW;
            OP_BEQ:  i = I_BEQ;
            OP_J:    i = I_J;
            OP_JAL:  i = I_JAL;
            default: i = I_ILL;
        endcase
        return i;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive un-acknowledged memory request cycles and flags
// the cycle on which the wait budget runs out.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 2);

    logic [W-1:0] count;

    // Any cycle that is not a waiting request cycle restarts the budget.
    always_ff @(posedge clk) begin
        if (reset || !active || ready) begin
            count <= '0;
        end else if (count != W'(TIMEOUT)) begin
            count <= count + W'(1);
        end
    end

    assign expired = active && !ready && (count == W'(TIMEOUT));

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with memory timeout and retire counter.
// Define SLT_INSN_EN to decode slt; otherwise it is treated as illegal.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             grf_we,
    output logic             dm_we,
    output logic [1:0]       regdst,
    output logic [1:0]       wdsel,
    output logic [1:0]       npcsel,
    output logic [1:0]       extop,
    output logic             alusrc,
    output logic [2:0]       aluop,
    output logic             illegal,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    state_t state;
    state_t next;
    insn_t  insn;
    logic   expired;

    assign insn    = decode_insn(op, func);
    assign mem_req = !reset && (state == S_FETCH || state == S_MEM);

    mem_wait_timer #(
        .TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .active (mem_req),
        .ready  (mem_ready),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            retired <= '0;
            fault   <= 1'b0;
        end else begin
            state <= next;
            if (next == S_FETCH && state != S_FETCH) begin
                retired <= retired + CNT_W'(1);
            end
            if (next == S_FAULT) begin
                fault <= 1'b1;
            end
        end
    end

    always_comb begin
        next    = state;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        grf_we  = 1'b0;
        dm_we   = 1'b0;
        illegal = 1'b0;
        npcsel  = NPC_PC4;
        unique case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    next  = S_DECODE;
                end else if (expired) begin
                    next = S_FAULT;
                end
            end
            S_DECODE: begin
                unique case (insn)
                    I_J: begin
                        pc_we  = 1'b1;
                        npcsel = NPC_J;
                        next   = S_FETCH;
                    end
                    I_JAL: begin
                        pc_we  = 1'b1;
                        grf_we = 1'b1;
                        npcsel = NPC_J;
                        next   = S_FETCH;
                    end
                    I_JR: begin
                        pc_we  = 1'b1;
                        npcsel = NPC_REG;
                        next   = S_FETCH;
                    end
                    I_ILL: begin
                        illegal = 1'b1;
                        next    = S_FETCH;
                    end
                    default: next = S_EXE;
                endcase
            end
            S_EXE: begin
                unique case (insn)
                    I_BEQ: begin
                        npcsel = NPC_BR;
                        pc_we  = zero;
                        next   = S_FETCH;
                    end
                    I_LW, I_SW: next = S_MEM;
                    default:    next = S_WB;
                endcase
            end
            S_MEM: begin
                dm_we = (insn == I_SW);
                if (mem_ready) begin
                    next = (insn == I_SW) ? S_FETCH : S_WB;
                end else if (expired) begin
                    next = S_FAULT;
                end
            end
            S_WB: begin
                grf_we = 1'b1;
                next   = S_FETCH;
            end
            S_FAULT: next = S_FAULT;
            default: next = S_FETCH;
        endcase
        // Nothing may write while reset is held.
        if (reset) begin
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            grf_we  = 1'b0;
            dm_we   = 1'b0;
            illegal = 1'b0;
        end
    end

    always_comb begin
        regdst = RD_RT;
        wdsel  = WD_ALU;
        extop  = EXT_SIGN;
        alusrc = 1'b0;
        aluop  = ALU_ADD;
        unique case (insn)
            I_ADDU: regdst = RD_RD;
            I_SUBU: begin
                regdst = RD_RD;
                aluop  = ALU_SUB;
            end
            I_SLT: begin
                regdst = RD_RD;
                aluop  = ALU_SLT;
            end
            I_ORI: begin
                extop  = EXT_ZERO;
                alusrc = 1'b1;
                aluop  = ALU_OR;
            end
            I_LUI: begin
                extop  = EXT_LUI;
                alusrc = 1'b1;
                aluop  = ALU_LUI;
            end
            I_LW: begin
                wdsel  = WD_MEM;
                alusrc = 1'b1;
            end
            I_SW:  alusrc = 1'b1;
            I_BEQ: aluop  = ALU_SUB;
            I_JAL: begin
                regdst = RD_RA;
                wdsel  = WD_PC4;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl with a 4-bit retire counter
// so that wrap-around is reachable in a short run.
module tb_mips_mc_ctrl;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       ir_we;
    logic       pc_we;
    logic       grf_we;
    logic       dm_we;
    logic [1:0] regdst;
    logic [1:0] wdsel;
    logic [1:0] npcsel;
    logic [1:0] extop;
    logic       alusrc;
    logic [2:0] aluop;
    logic       illegal;
    logic       fault;
    logic [3:0] retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl #(
        .CNT_W      (4),
        .MEM_TIMEOUT(15)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .func     (func),
        .zero     (zero),
        .mem_ready(mem_ready),
        .mem_req  (mem_req),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .grf_we   (grf_we),
        .dm_we    (dm_we),
        .regdst   (regdst),
        .wdsel    (wdsel),
        .npcsel   (npcsel),
        .extop    (extop),
        .alusrc   (alusrc),
        .aluop    (aluop),
        .illegal  (illegal),
        .fault    (fault),
        .retired  (retired)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] o, input logic [5:0] f,
                         input logic r, input logic z);
        op        = o;
        func      = f;
        mem_ready = r;
        zero      = z;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(OP_RTYPE, F_ADDU, 1'b1, 1'b0);
        tick;
        tick;
        chk("rst_retired", retired, 0);
        chk("rst_fault", fault, 0);
        chk("rst_ir_we", ir_we, 0);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_mem_req", mem_req, 0);
        reset = 1'b0;
        #1;

        // addu, memory always ready
        chk("addu_f_req", mem_req, 1);
        chk("addu_f_ir", ir_we, 1);
        chk("addu_f_pc", pc_we, 1);
        chk("addu_f_npc", npcsel, NPC_PC4);
        tick;
        chk("addu_d_ir", ir_we, 0);
        chk("addu_d_pc", pc_we, 0);
        chk("addu_d_grf", grf_we, 0);
        chk("addu_d_req", mem_req, 0);
        tick;
        chk("addu_e_grf", grf_we, 0);
        chk("addu_e_alu", aluop, ALU_ADD);
        tick;
        chk("addu_w_grf", grf_we, 1);
        chk("addu_w_dst", regdst, RD_RD);
        tick;
        chk("addu_f2_grf", grf_we, 0);
        chk("addu_ret", retired, 1);
        chk("addu_f2_req", mem_req, 1);

        // lw with three wait cycles in MEM
        drive(OP_LW, 6'd0, 1'b1, 1'b0);
        tick;
        tick;
        chk("lw_e_src", alusrc, 1);
        chk("lw_e_ext", extop, EXT_SIGN);
        drive(OP_LW, 6'd0, 1'b0, 1'b0);
        tick;
        chk("lw_m1_req", mem_req, 1);
        chk("lw_m1_dm", dm_we, 0);
        tick;
        tick;
        chk("lw_m3_grf", grf_we, 0);
        drive(OP_LW, 6'd0, 1'b1, 1'b0);
        chk("lw_m4_req", mem_req, 1);
        chk("lw_m4_grf", grf_we, 0);
        tick;
        chk("lw_w_grf", grf_we, 1);
        chk("lw_w_wd", wdsel, WD_MEM);
        chk("lw_w_dst", regdst, RD_RT);
        chk("lw_w_req", mem_req, 0);
        tick;
        chk("lw_f_grf", grf_we, 0);
        chk("lw_ret", retired, 2);

        // sw with one wait cycle
        drive(OP_SW, 6'd0, 1'b1, 1'b0);
        tick;
        tick;
        drive(OP_SW, 6'd0, 1'b0, 1'b0);
        tick;
        chk("sw_m1_dm", dm_we, 1);
        chk("sw_m1_req", mem_req, 1);
        drive(OP_SW, 6'd0, 1'b1, 1'b0);
        chk("sw_m2_dm", dm_we, 1);
        tick;
        chk("sw_f_dm", dm_we, 0);
        chk("sw_f_grf", grf_we, 0);
        chk("sw_ret", retired, 3);

        // beq not taken, then taken
        drive(OP_BEQ, 6'd0, 1'b1, 1'b0);
        tick;
        tick;
        chk("beq0_pc", pc_we, 0);
        chk("beq0_npc", npcsel, NPC_BR);
        tick;
        chk("beq0_ret", retired, 4);
        drive(OP_BEQ, 6'd0, 1'b1, 1'b1);
        tick;
        tick;
        chk("beq1_pc", pc_we, 1);
        chk("beq1_npc", npcsel, NPC_BR);
        tick;
        chk("beq1_ret", retired, 5);

        // jumps
        drive(OP_J, 6'd0, 1'b1, 1'b0);
        tick;
        chk("j_pc", pc_we, 1);
        chk("j_npc", npcsel, NPC_J);
        chk("j_grf", grf_we, 0);
        tick;
        chk("j_ret", retired, 6);
        drive(OP_JAL, 6'd0, 1'b1, 1'b0);
        tick;
        chk("jal_pc", pc_we, 1);
        chk("jal_grf", grf_we, 1);
        chk("jal_dst", regdst, RD_RA);
        chk("jal_wd", wdsel, WD_PC4);
        tick;
        chk("jal_ret", retired, 7);
        drive(OP_RTYPE, F_JR, 1'b1, 1'b0);
        tick;
        chk("jr_pc", pc_we, 1);
        chk("jr_npc", npcsel, NPC_REG);
        tick;
        chk("jr_ret", retired, 8);

        // unknown opcode
        drive(6'b111111, 6'd0, 1'b1, 1'b0);
        tick;
        chk("ill_pulse", illegal, 1);
        chk("ill_pc", pc_we, 0);
        chk("ill_grf", grf_we, 0);
        tick;
        chk("ill_clear", illegal, 0);
        chk("ill_req", mem_req, 1);
        chk("ill_ret", retired, 9);

        drive(OP_RTYPE, F_SLT, 1'b1, 1'b0);
        tick;
`ifdef SLT_INSN_EN
        chk("slt_ill", illegal, 0);
        tick;
        tick;
        chk("slt_w_grf", grf_we, 1);
        chk("slt_alu", aluop, ALU_SLT);
`else
        chk("slt_ill", illegal, 1);
`endif
        tick;
        chk("slt_ret", retired, 10);

        // six more retirements wrap the 4-bit counter
        for (int i = 0; i < 6; i++) begin
            drive(OP_J, 6'd0, 1'b1, 1'b0);
            tick;
            tick;
        end
        chk("wrap_ret", retired, 0);

        // ready arriving on the last allowed wait cycle is a success
        drive(OP_J, 6'd0, 1'b0, 1'b0);
        repeat (15) tick;
        chk("edge_req", mem_req, 1);
        chk("edge_fault", fault, 0);
        drive(OP_J, 6'd0, 1'b1, 1'b0);
        chk("edge_ir", ir_we, 1);
        tick;
        chk("edge_d_fault", fault, 0);
        chk("edge_d_pc", pc_we, 1);
        tick;
        chk("edge_ret", retired, 1);

        // sixteen missing acks in FETCH
        drive(OP_J, 6'd0, 1'b0, 1'b0);
        repeat (15) tick;
        chk("to_pre_fault", fault, 0);
        chk("to_pre_req", mem_req, 1);
        tick;
        chk("to_fault", fault, 1);
        chk("to_req", mem_req, 0);
        drive(OP_J, 6'd0, 1'b1, 1'b0);
        tick;
        chk("to_hold_fault", fault, 1);
        chk("to_hold_ir", ir_we, 0);
        chk("to_hold_pc", pc_we, 0);
        chk("to_hold_req", mem_req, 0);
        chk("to_hold_ret", retired, 1);

        reset = 1'b1;
        tick;
        chk("rst2_fault", fault, 0);
        chk("rst2_ret", retired, 0);
        chk("rst2_ir", ir_we, 0);
        reset = 1'b0;
        drive(OP_J, 6'd0, 1'b0, 1'b0);
        chk("rst2_fetch", mem_req, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
